// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mdu_ctrl_pkg                                                    |
// | Purpose  : HILO operation codes, default multi-cycle latencies and small   |
// |            decode helpers shared by the multiply/divide unit controller.   |
// | Ports    : none (package)                                                  |
// | Options  : MDU_MADD_EN - when defined, codes 9..12 (madd/maddu/msub/msubu) |
// |            are issued as multi-cycle accumulate operations.                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package mdu_ctrl_pkg;

  // E-stage HILO operation encoding
  localparam logic [4:0] HILO_NONE  = 5'd0;
  localparam logic [4:0] HILO_MULT  = 5'd1;
  localparam logic [4:0] HILO_MULTU = 5'd2;
  localparam logic [4:0] HILO_DIV   = 5'd3;
  localparam logic [4:0] HILO_DIVU  = 5'd4;
  localparam logic [4:0] HILO_MFHI  = 5'd5;
  localparam logic [4:0] HILO_MFLO  = 5'd6;
  localparam logic [4:0] HILO_MTHI  = 5'd7;
  localparam logic [4:0] HILO_MTLO  = 5'd8;
  localparam logic [4:0] HILO_MADD  = 5'd9;
  localparam logic [4:0] HILO_MADDU = 5'd10;
  localparam logic [4:0] HILO_MSUB  = 5'd11;
  localparam logic [4:0] HILO_MSUBU = 5'd12;

  // Default busy-cycle counts
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  // Controller state, derived from the busy counter
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == HILO_DIV) || (op == HILO_DIVU);
  endfunction

  function automatic logic is_madd_op(input logic [4:0] op);
    return (op >= HILO_MADD) && (op <= HILO_MSUBU);
  endfunction

  // Operation codes that launch a multi-cycle sequence (before Req gating)
  function automatic logic is_start_op(input logic [4:0] op);
    logic r;
    r = (op >= HILO_MULT) && (op <= HILO_DIVU) && (op != HILO_NONE);
    r = r || (MADD_EN && is_madd_op(op));
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_ctrl_arith.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mdu_ctrl_arith                                                  |
// | Purpose  : Combinational datapath of the multiply/divide unit. Produces    |
// |            the 64-bit {HI,LO} result for the requested operation and flags |
// |            divide-by-zero so the controller can leave HI/LO untouched.     |
// | Ports    : op_i       - HILO operation code                                |
// |            a_i, b_i   - rs / rt operands                                   |
// |            hilo_i     - current {HI,LO} (accumulate base)                  |
// |            result_o   - {HI,LO} result                                     |
// |            div_zero_o - div/divu with zero divisor                         |
// | Options  : MDU_MADD_EN - adds madd/maddu/msub/msubu results.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mdu_ctrl_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [4:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [63:0] hilo_i,
  output logic [63:0] result_o,
  output logic        div_zero_o
);

  logic [63:0]        w_prod_s;
  logic [63:0]        w_prod_u;
  logic               w_b_zero;
  logic               w_div_ovf;
  logic [31:0]        w_b_sdiv;
  logic [31:0]        w_b_udiv;
  logic signed [31:0] w_quo_s;
  logic signed [31:0] w_rem_s;
  logic [31:0]        w_quo_u;
  logic [31:0]        w_rem_u;

  // Low 64 bits of the sign-extended product equal the signed product
  assign w_prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
  assign w_prod_u = {32'h0, a_i} * {32'h0, b_i};

  assign w_b_zero   = (b_i == 32'h0);
  assign div_zero_o = is_div_op(op_i) && w_b_zero;

  // 0x80000000 / -1 overflows; dividing by 1 instead yields exactly the
  // architected answer (quotient 0x80000000, remainder 0). A zero divisor is
  // also replaced so the divider never sees it; its result is discarded.
  assign w_div_ovf = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
  assign w_b_sdiv  = (w_b_zero || w_div_ovf) ? 32'd1 : b_i;
  assign w_b_udiv  = w_b_zero ? 32'd1 : b_i;

  assign w_quo_s = $signed(a_i) / $signed(w_b_sdiv);
  assign w_rem_s = $signed(a_i) % $signed(w_b_sdiv);
  assign w_quo_u = a_i / w_b_udiv;
  assign w_rem_u = a_i % w_b_udiv;

  always_comb begin
    result_o = hilo_i;
    case (op_i)
      HILO_MULT:  result_o = w_prod_s;
      HILO_MULTU: result_o = w_prod_u;
      HILO_DIV:   result_o = {w_rem_s, w_quo_s};
      HILO_DIVU:  result_o = {w_rem_u, w_quo_u};
`ifdef MDU_MADD_EN
      HILO_MADD:  result_o = hilo_i + w_prod_s;
      HILO_MADDU: result_o = hilo_i + w_prod_u;
      HILO_MSUB:  result_o = hilo_i - w_prod_s;
      HILO_MSUBU: result_o = hilo_i - w_prod_u;
`endif
      default:    result_o = hilo_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mdu_ctrl                                                        |
// | Purpose  : Multiply/divide unit controller for the 5-stage MIPS pipeline.  |
// |            Owns HI/LO, sequences multi-cycle mult/div issued from E,       |
// |            raises the D-stage stall for HILO-class instructions and serves |
// |            mfhi/mflo reads.                                                |
// | Ports    : clk, reset_n (async, active low)                                |
// |            E_HILOOp, E_A, E_B - E-stage op and forwarded operands          |
// |            Req                - exception/interrupt, suppresses E op       |
// |            D_isHILO           - D-stage instruction is HILO class          |
// |            start, busy, stall - issue / in-flight / D-stage stall          |
// |            HILO_rdata         - mfhi/mflo read data                        |
// |            HI, LO             - architectural HI/LO registers              |
// | Options  : MDU_MADD_EN - accept madd/maddu/msub/msubu (codes 9..12).       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  E_HILOOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        Req,
  input  logic        D_isHILO,
  output logic        start,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HILO_rdata,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] c_mult_cnt = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] c_div_cnt  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      pend_q, pend_d;
  logic             pend_wr_q, pend_wr_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic             w_state;
  logic [63:0]      w_arith_res;
  logic             w_div_zero;
  logic             w_start;

  mdu_ctrl_arith u_arith (
    .op_i       (E_HILOOp),
    .a_i        (E_A),
    .b_i        (E_B),
    .hilo_i     ({hi_q, lo_q}),
    .result_o   (w_arith_res),
    .div_zero_o (w_div_zero)
  );

  assign w_state = (cnt_q != '0) ? ST_BUSY : ST_IDLE;
  assign w_start = is_start_op(E_HILOOp) && !Req;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      pend_q    <= 64'h0;
      pend_wr_q <= 1'b0;
      hi_q      <= 32'h0;
      lo_q      <= 32'h0;
    end else begin
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Next-state logic
  always_comb begin
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (w_state)
      ST_IDLE: begin
        if (w_start) begin
          cnt_d     = is_div_op(E_HILOOp) ? c_div_cnt : c_mult_cnt;
          pend_d    = w_arith_res;
          // A zero divisor still occupies the unit but must not write HI/LO
          pend_wr_d = !w_div_zero;
        end else if (!Req && (E_HILOOp == HILO_MTHI)) begin
          hi_d = E_A;
        end else if (!Req && (E_HILOOp == HILO_MTLO)) begin
          lo_d = E_A;
        end
      end
      ST_BUSY: begin
        // Issue/mt while busy cannot happen legally (stall); ignore it.
        // Req does not cancel an in-flight op: it belongs to a retired insn.
        cnt_d = cnt_q - c_cnt_one;
        if ((cnt_q == c_cnt_one) && pend_wr_q) begin
          {hi_d, lo_d} = pend_q;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // Outputs
  always_comb begin
    start      = w_start;
    busy       = (w_state == ST_BUSY);
    stall      = D_isHILO && (w_start || (w_state == ST_BUSY));
    HILO_rdata = 32'h0;
    if (E_HILOOp == HILO_MFHI) begin
      HILO_rdata = hi_q;
    end else if (E_HILOOp == HILO_MFLO) begin
      HILO_rdata = lo_q;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mdu_ctrl                                                     |
// | Purpose  : Self-checking bench for mdu_ctrl: directed scenarios with       |
// |            literal expectations followed by randomized traffic compared    |
// |            every cycle against a cycle-stamped behavioural model.          |
// | Options  : MDU_MADD_EN - also exercises the accumulate operations.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  E_HILOOp = 5'd0;
  logic [31:0] E_A = 32'h0;
  logic [31:0] E_B = 32'h0;
  logic        Req = 1'b0;
  logic        D_isHILO = 1'b0;
  logic        start;
  logic        busy;
  logic        stall;
  logic [31:0] HILO_rdata;
  logic [31:0] HI;
  logic [31:0] LO;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .E_HILOOp   (E_HILOOp),
    .E_A        (E_A),
    .E_B        (E_B),
    .Req        (Req),
    .D_isHILO   (D_isHILO),
    .start      (start),
    .busy       (busy),
    .stall      (stall),
    .HILO_rdata (HILO_rdata),
    .HI         (HI),
    .LO         (LO)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // An op issued in cycle t is busy in cycles t+1 .. t+N and its result is
  // applied to HI/LO at the edge that ends cycle t+N.
  longint unsigned cyc = 0;
  longint unsigned m_t = 0;
  longint unsigned m_end = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;
  logic [4:0]  m_op = 5'd0;
  logic [31:0] m_a = 32'h0;
  logic [31:0] m_b = 32'h0;

  function automatic bit m_busy(input longint unsigned c);
    return (c > m_t) && (c <= m_end);
  endfunction

  function automatic bit mdl_start_op(input logic [4:0] op);
`ifdef MDU_MADD_EN
    return (op >= 5'd1 && op <= 5'd4) || (op >= 5'd9 && op <= 5'd12);
`else
    return (op >= 5'd1 && op <= 5'd4);
`endif
  endfunction

  // Architectural result of an op applied to the current model HI/LO
  function automatic void mdl_apply(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     acc, res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    acc = {m_hi, m_lo};
    res = acc;
    case (op)
      5'd1: res = sa * sb;
      5'd2: res = ua * ub;
      5'd3: if (b != 0) begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
      5'd4: if (b != 0) begin uq = ua / ub; ur = ua % ub; res = {ur[31:0], uq[31:0]}; end
      5'd9:  res = acc + (sa * sb);
      5'd10: res = acc + (ua * ub);
      5'd11: res = acc - (sa * sb);
      5'd12: res = acc - (ua * ub);
      default: res = acc;
    endcase
    {m_hi, m_lo} = res;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hi  = 32'h0;
      m_lo  = 32'h0;
      m_t   = cyc;
      m_end = cyc;
    end else begin
      if (m_busy(cyc)) begin
        if (cyc == m_end) mdl_apply(m_op, m_a, m_b);
      end else if (mdl_start_op(E_HILOOp) && !Req) begin
        m_op  = E_HILOOp;
        m_a   = E_A;
        m_b   = E_B;
        m_t   = cyc;
        m_end = cyc + ((E_HILOOp == 5'd3 || E_HILOOp == 5'd4) ? DC : MC);
      end else if (!Req && E_HILOOp == 5'd7) begin
        m_hi = E_A;
      end else if (!Req && E_HILOOp == 5'd8) begin
        m_lo = E_A;
      end
      cyc = cyc + 1;
    end
  end

  // ---------------------------------------------------------- compare
  bit          e_start, e_busy;
  logic [31:0] e_rdata;

  always @(negedge clk) begin
    if (reset_n) begin
      e_start = mdl_start_op(E_HILOOp) && !Req;
      e_busy  = m_busy(cyc);
      e_rdata = (E_HILOOp == 5'd5) ? m_hi : (E_HILOOp == 5'd6) ? m_lo : 32'h0;
      chk("start", start, e_start);
      chk("busy", busy, e_busy);
      chk("stall", stall, D_isHILO && (e_start || e_busy));
      chk("HILO_rdata", HILO_rdata, e_rdata);
      chk("HI", HI, m_hi);
      chk("LO", LO, m_lo);
    end
  end

  // Issuing while busy is illegal; the bench must never do it
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!(busy && (start || (!Req && (E_HILOOp == 5'd7 || E_HILOOp == 5'd8)))))
        else $error("protocol violation: HILO op issued while busy");
    end
  end

  // --------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic rq, input logic d);
    E_HILOOp = op;
    E_A      = a;
    E_B      = b;
    Req      = rq;
    D_isHILO = d;
  endtask

  // Issue in cycle T, then hold 'none' with D_isHILO=1; returns in cycle T+1+n
  task automatic issue_wait(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int n);
    drive(op, a, b, 1'b0, 1'b1);
    tick();
    drive(5'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    repeat (n) tick();
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] sp [5];
    sp[0] = 32'h0; sp[1] = 32'h1; sp[2] = 32'hFFFF_FFFF;
    sp[3] = 32'h8000_0000; sp[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    // Reset state
    #1;
    chk("reset_HI", HI, 32'h0);
    chk("reset_LO", LO, 32'h0);
    chk("reset_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // mult -2 * 3
    issue_wait(5'd1, 32'hFFFF_FFFE, 32'd3, 4);
    chk("mult_busy_T5", busy, 1'b1);
    chk("mult_stall_T5", stall, 1'b1);
    tick();
    chk("mult_busy_T6", busy, 1'b0);
    chk("mult_stall_T6", stall, 1'b0);
    chk("mult_HI", HI, 32'hFFFF_FFFF);
    chk("mult_LO", LO, 32'hFFFF_FFFA);
    drive(5'd6, 32'h0, 32'h0, 1'b0, 1'b1);
    #1 chk("mflo_rdata", HILO_rdata, 32'hFFFF_FFFA);
    tick();

    // multu same operands
    issue_wait(5'd2, 32'hFFFF_FFFE, 32'd3, 5);
    chk("multu_HI", HI, 32'h0000_0002);
    chk("multu_LO", LO, 32'hFFFF_FFFA);

    // div -7 / 2
    issue_wait(5'd3, 32'hFFFF_FFF9, 32'd2, 9);
    chk("div_busy_T10", busy, 1'b1);
    tick();
    chk("div_busy_T11", busy, 1'b0);
    chk("div_LO", LO, 32'hFFFF_FFFD);
    chk("div_HI", HI, 32'hFFFF_FFFF);

    // divu by zero leaves HI/LO untouched
    issue_wait(5'd4, 32'd7, 32'd0, 9);
    chk("divu0_busy_T10", busy, 1'b1);
    tick();
    chk("divu0_HI", HI, 32'hFFFF_FFFF);
    chk("divu0_LO", LO, 32'hFFFF_FFFD);

    // Signed overflow case
    issue_wait(5'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    chk("divovf_LO", LO, 32'h8000_0000);
    chk("divovf_HI", HI, 32'h0);

    // Req during an in-flight mult does not cancel it
    drive(5'd1, 32'd5, 32'd7, 1'b0, 1'b0);
    tick();
    drive(5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(5'd1, 32'd9, 32'd9, 1'b1, 1'b0);
    tick();
    drive(5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (3) tick();
    chk("reqbusy_HI", HI, 32'h0);
    chk("reqbusy_LO", LO, 32'd35);

    // mult issued with Req is suppressed
    drive(5'd1, 32'd9, 32'd9, 1'b1, 1'b0);
    #1 chk("req_start", start, 1'b0);
    tick();
    drive(5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("req_busy", busy, 1'b0);
    repeat (6) tick();
    chk("req_LO", LO, 32'd35);

    // mthi, then mthi under Req
    drive(5'd7, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
    tick();
    chk("mthi_HI", HI, 32'h1234_5678);
    chk("mthi_busy", busy, 1'b0);
    drive(5'd7, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0);
    tick();
    chk("mthi_req_HI", HI, 32'h1234_5678);

    // Asynchronous reset in the middle of a div
    drive(5'd3, 32'd100, 32'd3, 1'b0, 1'b0);
    tick();
    drive(5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_HI", HI, 32'h0);
    chk("arst_LO", LO, 32'h0);
    chk("arst_busy", busy, 1'b0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (12) tick();
    chk("arst_nocommit_LO", LO, 32'h0);
    chk("arst_nocommit_HI", HI, 32'h0);

`ifdef MDU_MADD_EN
    drive(5'd8, 32'd5, 32'h0, 1'b0, 1'b0);
    tick();
    drive(5'd7, 32'd0, 32'h0, 1'b0, 1'b0);
    tick();
    issue_wait(5'd9, 32'd2, 32'd3, 5);
    chk("madd_LO", LO, 32'd11);
    chk("madd_HI", HI, 32'h0);
`endif

    // Randomized traffic, legal with respect to the busy protocol
    for (int i = 0; i < 600; i++) begin
      logic [4:0] op;
      if (m_busy(cyc)) begin
        case ($urandom_range(0, 3))
          0:       op = 5'd0;
          1:       op = 5'd5;
          2:       op = 5'd6;
          default: op = 5'($urandom_range(13, 31));
        endcase
      end else if ($urandom_range(0, 9) == 0) begin
        op = 5'($urandom_range(13, 31));
      end else begin
        op = 5'($urandom_range(0, 12));
      end
      drive(op, rand_operand(), rand_operand(), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      tick();
    end

    drive(5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (DC + 2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
